// File: rtl/scope_pkg.sv
// Shared types and constants for the oscilloscope trigger/capture block.
package scope_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_ARMED,
        ST_POST,
        ST_DONE
    } state_e;

    localparam logic [1:0] MODE_AUTO   = 2'd0;
    localparam logic [1:0] MODE_NORMAL = 2'd1;
    localparam logic [1:0] MODE_SINGLE = 2'd2;
    localparam logic [1:0] MODE_STOP   = 2'd3;

endpackage

// File: rtl/scope_ram.sv
// Simple dual-port capture RAM: one write port, registered read port.
module scope_ram #(
    parameter int unsigned N  = 10,
    parameter int unsigned AW = 10
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [N-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [N-1:0]  rdata_o
);

    localparam int unsigned DEPTH = 2**AW;

    logic [N-1:0] mem_q [DEPTH];

    // Storage array; contents are not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read data, cleared by reset.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rdata_o <= '0;
        end else begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/scope_trigger.sv
// Edge trigger with pretrigger capture into a circular buffer, frame readout.
module scope_trigger
    import scope_pkg::*;
#(
    parameter int unsigned N       = 10,
    parameter int unsigned AW      = 10,
    parameter int unsigned AUTO_TO = 65536
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic          smpl_valid,
    input  logic [N-1:0]  smpl,
    input  logic [N-1:0]  level,
    input  logic          edge_sel,
    input  logic [1:0]    mode,
    input  logic          arm,
    input  logic [AW-1:0] pre,
    input  logic [AW-1:0] rd_addr,
    output logic [N-1:0]  rd_data,
    output logic          frame_valid,
    input  logic          frame_ack,
    output logic          trig,
    output logic          auto_fired
);

    localparam int unsigned DEPTH = 2**AW;
    localparam int unsigned TW    = (AUTO_TO > 0) ? $clog2(AUTO_TO + 1) : 1;

    state_e        state_q;
    logic [AW-1:0] wp_q;
    logic [AW-1:0] pre_q;
    logic [AW-1:0] start_q;
    logic [AW:0]   cnt_q;
    logic [TW-1:0] to_q;
    logic [N-1:0]  prev_q;
    logic          prev_ld_q;
    logic          trig_q;
    logic          auto_q;
    logic          fv_q;

    logic          we_c;
    logic          hit_c;
    logic          force_c;
    logic          start_c;
    logic [AW:0]   post_len_c;
    logic [AW-1:0] raddr_c;

    // Write qualification, trigger detection and capture-start decode.
    always_comb begin
        we_c       = 1'b0;
        hit_c      = 1'b0;
        force_c    = 1'b0;
        start_c    = 1'b0;
        post_len_c = (AW+1)'(DEPTH) - {1'b0, pre_q};
        raddr_c    = start_q + rd_addr;

        if (smpl_valid) begin
            if (state_q == ST_POST) begin
                we_c = 1'b1;
            end else if ((state_q == ST_FILL || state_q == ST_ARMED) && mode != MODE_STOP) begin
                we_c = 1'b1;
            end
        end

        if (prev_ld_q) begin
            if (edge_sel) begin
                hit_c = (prev_q >= level) && (level > smpl);
            end else begin
                hit_c = (prev_q < level) && (level <= smpl);
            end
        end

        force_c = (mode == MODE_AUTO) && (to_q == TW'(AUTO_TO));

        if (state_q == ST_IDLE) begin
            start_c = (mode == MODE_AUTO) || (mode == MODE_NORMAL) ||
                      ((mode == MODE_SINGLE) && arm);
        end else if (state_q == ST_DONE && frame_ack) begin
            start_c = (mode == MODE_AUTO) || (mode == MODE_NORMAL);
        end
    end

    // Capture FSM with write pointer, counters and registered status outputs.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= ST_IDLE;
            wp_q      <= '0;
            pre_q     <= '0;
            start_q   <= '0;
            cnt_q     <= '0;
            to_q      <= '0;
            prev_q    <= '0;
            prev_ld_q <= 1'b0;
            trig_q    <= 1'b0;
            auto_q    <= 1'b0;
            fv_q      <= 1'b0;
        end else begin
            trig_q <= 1'b0;
            if (we_c) begin
                wp_q <= wp_q + AW'(1);
            end

            if (start_c) begin
                pre_q     <= pre;
                cnt_q     <= '0;
                to_q      <= '0;
                prev_ld_q <= 1'b0;
                fv_q      <= 1'b0;
                state_q   <= (pre == '0) ? ST_ARMED : ST_FILL;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_IDLE;
                    end
                    ST_FILL: begin
                        if (mode == MODE_STOP) begin
                            state_q <= ST_IDLE;
                        end else if (smpl_valid) begin
                            cnt_q <= cnt_q + (AW+1)'(1);
                            if (cnt_q + (AW+1)'(1) == {1'b0, pre_q}) begin
                                state_q   <= ST_ARMED;
                                to_q      <= '0;
                                prev_ld_q <= 1'b0;
                            end
                        end
                    end
                    ST_ARMED: begin
                        if (mode == MODE_STOP) begin
                            state_q <= ST_IDLE;
                        end else if (smpl_valid) begin
                            prev_q    <= smpl;
                            prev_ld_q <= 1'b1;
                            if (hit_c || force_c) begin
                                trig_q  <= 1'b1;
                                auto_q  <= !hit_c;
                                start_q <= wp_q - pre_q;
                                cnt_q   <= (AW+1)'(1);
                                if (post_len_c == (AW+1)'(1)) begin
                                    state_q <= ST_DONE;
                                    fv_q    <= 1'b1;
                                end else begin
                                    state_q <= ST_POST;
                                end
                            end else if (to_q != TW'(AUTO_TO)) begin
                                to_q <= to_q + TW'(1);
                            end
                        end
                    end
                    ST_POST: begin
                        if (smpl_valid) begin
                            cnt_q <= cnt_q + (AW+1)'(1);
                            if (cnt_q + (AW+1)'(1) == post_len_c) begin
                                state_q <= ST_DONE;
                                fv_q    <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (frame_ack) begin
                            fv_q    <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    scope_ram #(
        .N  (N),
        .AW (AW)
    ) u_ram (
        .clk     (clk),
        .n_reset (n_reset),
        .we_i    (we_c),
        .waddr_i (wp_q),
        .wdata_i (smpl),
        .raddr_i (raddr_c),
        .rdata_o (rd_data)
    );

    assign frame_valid = fv_q;
    assign trig        = trig_q;
    assign auto_fired  = auto_q;

endmodule

// File: tb/tb_scope_trigger.sv
// Scoreboard bench for scope_trigger with a 16-entry buffer.
module tb_scope_trigger;

    localparam int unsigned N       = 10;
    localparam int unsigned AW      = 4;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned AUTO_TO = 8;

    logic          clk = 1'b0;
    logic          n_reset;
    logic          smpl_valid;
    logic [N-1:0]  smpl;
    logic [N-1:0]  level;
    logic          edge_sel;
    logic [1:0]    mode;
    logic          arm;
    logic [AW-1:0] pre;
    logic [AW-1:0] rd_addr;
    logic [N-1:0]  rd_data;
    logic          frame_valid;
    logic          frame_ack;
    logic          trig;
    logic          auto_fired;

    int errors = 0;
    int checks = 0;
    logic [N-1:0] exp_q [$];
    int           trig_cnt;
    int           trig_idx;
    logic [N-1:0] trig_val;

    always #5 clk = ~clk;

    scope_trigger #(
        .N       (N),
        .AW      (AW),
        .AUTO_TO (AUTO_TO)
    ) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .smpl_valid  (smpl_valid),
        .smpl        (smpl),
        .level       (level),
        .edge_sel    (edge_sel),
        .mode        (mode),
        .arm         (arm),
        .pre         (pre),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .trig        (trig),
        .auto_fired  (auto_fired)
    );

    function automatic logic [N-1:0] sq(input int i);
        return (((i / 3) % 2) == 0) ? 10'd400 : 10'd200;
    endfunction

    task automatic do_reset();
        n_reset    = 1'b0;
        smpl_valid = 1'b0;
        smpl       = '0;
        level      = 10'd512;
        edge_sel   = 1'b0;
        mode       = 2'd3;
        arm        = 1'b0;
        pre        = 4'd4;
        rd_addr    = '0;
        frame_ack  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_reset = 1'b1;
    endtask

    task automatic feed(input int idx, input logic [N-1:0] v);
        @(negedge clk);
        smpl       = v;
        smpl_valid = 1'b1;
        @(posedge clk);
        #1;
        if (trig === 1'b1) begin
            trig_cnt++;
            trig_idx = idx;
            trig_val = v;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            smpl_valid = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ack();
        @(negedge clk);
        smpl_valid = 1'b0;
        frame_ack  = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL ack_release: frame_valid=%b expected 0", frame_valid);
        end
        @(negedge clk);
        frame_ack = 1'b0;
    endtask

    task automatic pulse_arm();
        @(negedge clk);
        smpl_valid = 1'b0;
        arm        = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic read_frame(input string name);
        logic [N-1:0] e;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            smpl_valid = 1'b0;
            rd_addr    = AW'(i);
            @(posedge clk);
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s[%0d]: scoreboard empty, got %0d", name, i, rd_data);
            end else begin
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    errors++;
                    $display("FAIL %s[%0d]: got %0d expected %0d", name, i, rd_data, e);
                end
            end
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        #1;
        check_val("reset_rd_data", int'(rd_data), 0);
        check_val("reset_frame_valid", int'(frame_valid), 0);
        check_val("reset_trig", int'(trig), 0);
        check_val("reset_auto_fired", int'(auto_fired), 0);
        do_reset();
    endtask

    task automatic test_ramp();
        do_reset();
        mode = 2'd1;
        idle(2);
        trig_cnt = 0;
        for (int i = 0; i < 32; i++) feed(i, N'(500 + i));
        check_val("ramp_trig_count", trig_cnt, 1);
        check_val("ramp_trig_value", int'(trig_val), 512);
        check_val("ramp_frame_valid", int'(frame_valid), 1);
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(N'(508 + i));
        read_frame("ramp_frame");
        check_val("ramp_hold_valid", int'(frame_valid), 1);
        ack();
    endtask

    task automatic test_auto();
        int n;
        do_reset();
        mode = 2'd0;
        idle(2);
        trig_cnt = 0;
        n = -1;
        for (int i = 0; i < 64; i++) begin
            feed(i, 10'd100);
            if (frame_valid === 1'b1) begin
                n = i + 1;
                break;
            end
        end
        check_val("auto_samples_to_frame", n, 24);
        check_val("auto_trig_index", trig_idx, 12);
        check_val("auto_fired_set", int'(auto_fired), 1);
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(10'd100);
        read_frame("auto_frame");
        ack();
        trig_cnt = 0;
        for (int i = 0; i < 5; i++) feed(i, 10'd100);
        feed(5, 10'd600);
        check_val("auto_real_trig", trig_cnt, 1);
        check_val("auto_fired_cleared", int'(auto_fired), 0);
        for (int i = 0; i < 40 && frame_valid !== 1'b1; i++) feed(6 + i, 10'd600);
        check_val("auto_real_frame_valid", int'(frame_valid), 1);
        for (int i = 0; i < 4; i++) exp_q.push_back(10'd100);
        for (int i = 0; i < 12; i++) exp_q.push_back(10'd600);
        read_frame("auto_real_frame");
    endtask

    task automatic test_single();
        do_reset();
        mode = 2'd2;
        idle(2);
        trig_cnt = 0;
        for (int i = 0; i < 32; i++) feed(i, N'(500 + i));
        check_val("single_no_arm_trig", trig_cnt, 0);
        check_val("single_no_arm_valid", int'(frame_valid), 0);
        pulse_arm();
        for (int i = 0; i < 32; i++) feed(i, N'(500 + i));
        check_val("single_first_trig", trig_cnt, 1);
        check_val("single_first_valid", int'(frame_valid), 1);
        ack();
        for (int i = 0; i < 32; i++) feed(i, N'(500 + i));
        check_val("single_after_ack_trig", trig_cnt, 1);
        check_val("single_after_ack_valid", int'(frame_valid), 0);
        pulse_arm();
        for (int i = 0; i < 32; i++) feed(i, N'(500 + i));
        check_val("single_second_trig", trig_cnt, 2);
        check_val("single_second_valid", int'(frame_valid), 1);
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(N'(508 + i));
        read_frame("single_frame");
    endtask

    task automatic test_falling();
        do_reset();
        mode     = 2'd1;
        level    = 10'd300;
        edge_sel = 1'b1;
        idle(2);
        trig_cnt = 0;
        for (int i = 0; i < 30; i++) feed(i, sq(i));
        check_val("fall_trig_count", trig_cnt, 1);
        check_val("fall_trig_index", trig_idx, 9);
        check_val("fall_trig_value", int'(trig_val), 200);
        for (int i = 5; i <= 20; i++) exp_q.push_back(sq(i));
        read_frame("fall_frame");
    endtask

    task automatic test_pre_bounds();
        do_reset();
        mode = 2'd1;
        pre  = 4'd0;
        idle(2);
        trig_cnt = 0;
        for (int i = 0; i < 40; i++) feed(i, N'(490 + i));
        check_val("pre0_trig_index", trig_idx, 22);
        check_val("pre0_frame_valid", int'(frame_valid), 1);
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(N'(512 + i));
        read_frame("pre0_frame");

        do_reset();
        mode = 2'd1;
        pre  = 4'd15;
        idle(2);
        trig_cnt = 0;
        for (int i = 0; i < 30; i++) feed(i, N'(490 + i));
        check_val("pre15_trig_index", trig_idx, 22);
        check_val("pre15_frame_valid", int'(frame_valid), 1);
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(N'(497 + i));
        read_frame("pre15_frame");
    endtask

    task automatic test_reset_post();
        do_reset();
        mode = 2'd1;
        idle(2);
        trig_cnt = 0;
        for (int i = 0; i < 32 && trig_cnt == 0; i++) feed(i, N'(500 + i));
        check_val("rpost_trig_seen", trig_cnt, 1);
        #1;
        n_reset = 1'b0;
        #1;
        check_val("rpost_trig", int'(trig), 0);
        check_val("rpost_frame_valid", int'(frame_valid), 0);
        check_val("rpost_auto_fired", int'(auto_fired), 0);
        check_val("rpost_rd_data", int'(rd_data), 0);
        @(negedge clk);
        n_reset = 1'b1;
        for (int i = 0; i < 10; i++) feed(i, N'(520 + i));
        check_val("rpost_no_frame", int'(frame_valid), 0);
    endtask

    task automatic test_stop_armed();
        do_reset();
        mode = 2'd1;
        idle(2);
        trig_cnt = 0;
        for (int i = 0; i < 6; i++) feed(i, N'(500 + i));
        mode = 2'd3;
        for (int i = 6; i < 40; i++) feed(i, N'(500 + i));
        check_val("stop_no_trig", trig_cnt, 0);
        check_val("stop_no_frame", int'(frame_valid), 0);
        mode = 2'd1;
        idle(2);
        for (int i = 0; i < 32; i++) feed(i, N'(500 + i));
        check_val("stop_resume_trig", trig_cnt, 1);
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(N'(508 + i));
        read_frame("stop_resume_frame");
    endtask

    initial begin
        do_reset();
        test_reset();
        test_ramp();
        test_auto();
        test_single();
        test_falling();
        test_pre_bounds();
        test_reset_post();
        test_stop_armed();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
